lfsr_bit_packer: RTL and testbench



---
 rtl/lfsr_bit_packer.sv | 148 ++++++++++++++
 tb/tb_lfsr_bit_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bit_packer.sv
// Packs the valid-qualified serial LFSR keystream MSB-first into W-bit words and buffers them in a FIFO.
// Optional repetition-count health test (alarm port) enabled by defining LFSR_PACK_HEALTH_EN.
module lfsr_bit_packer #(
    parameter int W          = 32,
    parameter int DEPTH      = 4,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in,
    input  logic                     s_valid,
    input  logic                     flush,
    output logic [W-1:0]             m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    input  logic                     clr_err
`ifdef LFSR_PACK_HEALTH_EN
    ,
    output logic                     alarm
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(W);

    logic [W-2:0]  shreg;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic          accept;
    logic          word_done;
    logic [W-1:0]  word;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          hit;
    logic          blocked;

`ifdef LFSR_PACK_HEALTH_EN
    logic [7:0] run_cnt;
    logic [7:0] run_nxt;
    logic       last_bit;

    // Run length including the bit sampled this cycle; saturates at 255.
    always_comb begin
        run_nxt = 8'd1;
        if (run_cnt != 8'd0 && s_in == last_bit)
            run_nxt = (run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1;
        hit     = accept && !clr_err && (run_nxt == 8'(RCT_CUTOFF));
        blocked = alarm || hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
            alarm    <= 1'b0;
        end else if (clr_err) begin
            run_cnt  <= '0;
            alarm    <= 1'b0;
        end else if (accept) begin
            run_cnt  <= run_nxt;
            last_bit <= s_in;
            if (hit)
                alarm <= 1'b1;
        end
    end
`else
    always_comb begin
        hit     = 1'b0;
        blocked = 1'b0;
    end
`endif

    always_comb begin
        accept    = s_valid && !flush;
        word_done = accept && (bit_cnt == CW'(W - 1));
        word      = {shreg, s_in};
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = !empty && m_ready && !flush;
        push_req  = word_done && !blocked;
        // A full FIFO still takes the word when the head leaves in the same cycle.
        push      = push_req && (!full || pop);
        drop      = push_req && !push;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (s_valid) begin
            shreg   <= word[W-2:0];
            bit_cnt <= (hit || bit_cnt == CW'(W - 1)) ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A drop coinciding with clr_err restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_err)
                drop_cnt <= 16'd1;
            else if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end else if (clr_err) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    always_comb begin
        m_data  = mem[rd_ptr[AW-1:0]];
        m_valid = !empty;
        fill    = wr_ptr - rd_ptr;
    end

endmodule

// File: tb/tb_lfsr_bit_packer.sv
// Randomized plus directed bench for lfsr_bit_packer against a queue-based reference model.
// Exercises the alarm path when compiled with LFSR_PACK_HEALTH_EN.
module tb_lfsr_bit_packer;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int RCT   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_in = 1'b0;
    logic          s_valid = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [$clog2(DEPTH):0] fill;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          clr_err = 1'b0;
`ifdef LFSR_PACK_HEALTH_EN
    logic          alarm;
`endif

    always #5 clk = ~clk;

    lfsr_bit_packer #(.W(W), .DEPTH(DEPTH), .RCT_CUTOFF(RCT)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_in     (s_in),
        .s_valid  (s_valid),
        .flush    (flush),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .fill     (fill),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_err  (clr_err)
`ifdef LFSR_PACK_HEALTH_EN
        ,
        .alarm    (alarm)
`endif
    );

    int tests  = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: words in a queue, partial word as a queue of bits.
    logic [W-1:0] mq[$];
    bit           bq[$];
    bit           m_ovf;
    int           m_drops;
    int           m_run;
    bit           m_last;
    bit           m_alarm;

    task automatic model_step();
        bit           pop;
        bit           want_push;
        bit           dropped;
        bit           hit;
        int           pre;
        int           nr;
        logic [W-1:0] w;
        if (rst) begin
            mq.delete(); bq.delete();
            m_ovf = 0; m_drops = 0; m_run = 0; m_last = 0; m_alarm = 0;
            return;
        end
        pop = (mq.size() != 0) && m_ready;
        pre = mq.size();
        want_push = 0; dropped = 0; hit = 0; nr = 0; w = '0;
        if (flush) begin
            mq.delete(); bq.delete();
        end else begin
            if (s_valid) begin
`ifdef LFSR_PACK_HEALTH_EN
                nr = (m_run != 0 && s_in == m_last) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                hit = !clr_err && (nr == RCT);
`endif
                if (hit) begin
                    bq.delete();
                end else begin
                    bq.push_back(s_in);
                    if (bq.size() == W) begin
                        for (int i = 0; i < W; i++) w[W-1-i] = bq[i];
                        bq.delete();
                        want_push = !m_alarm;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (want_push) begin
                if (pre < DEPTH || pop) mq.push_back(w);
                else dropped = 1;
            end
        end
        if (dropped) begin
            m_ovf = 1;
            m_drops = clr_err ? 1 : ((m_drops < 65535) ? m_drops + 1 : m_drops);
        end else if (clr_err) begin
            m_ovf = 0; m_drops = 0;
        end
`ifdef LFSR_PACK_HEALTH_EN
        if (clr_err) begin
            m_run = 0; m_alarm = 0;
        end else if (s_valid && !flush) begin
            m_run = nr; m_last = s_in;
            if (hit) m_alarm = 1;
        end
`endif
    endtask

    task automatic compare_model();
        check("m_valid", m_valid, mq.size() != 0);
        check("fill", fill, mq.size());
        if (mq.size() != 0) check("m_data", m_data, mq[0]);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drops);
`ifdef LFSR_PACK_HEALTH_EN
        check("alarm", alarm, m_alarm);
`endif
    endtask

    task automatic step(input bit sv, input bit si, input bit rdy,
                        input bit fl = 0, input bit clr = 0, input bit r = 0);
        s_valid = sv; s_in = si; m_ready = rdy; flush = fl; clr_err = clr; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic send_range(input logic [W-1:0] w, input int hi, input int lo,
                              input bit toggle, input bit rdy);
        for (int i = hi; i >= lo; i--) begin
            if (toggle) step(0, 1'($urandom), rdy);
            step(1, w[i], rdy);
        end
    endtask

    logic [W-1:0] rnd;
    int           pct;

    initial begin
        // Reset state
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_fill", fill, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // Continuous stream, one-cycle latency
        send_range(32'hAAAA5555, 31, 1, 0, 1);
        check("t1_pre_valid", m_valid, 0);
        send_range(32'hAAAA5555, 0, 0, 0, 1);
        check("t1_valid", m_valid, 1);
        check("t1_data", m_data, 32'hAAAA5555);
        step(0, 0, 1);
        check("t1_fill_after", fill, 0);

        // s_valid toggling
        send_range(32'hAAAA5555, 31, 1, 1, 1);
        check("t2_pre_valid", m_valid, 0);
        send_range(32'hAAAA5555, 0, 0, 1, 1);
        check("t2_valid", m_valid, 1);
        check("t2_data", m_data, 32'hAAAA5555);
        step(0, 0, 1);

        // Overflow with stalled consumer
        for (int k = 1; k <= 5; k++) send_range(W'(k), 31, 0, 0, 0);
        check("t3_fill", fill, 4);
        check("t3_overflow", overflow, 1);
        check("t3_drop_cnt", drop_cnt, 1);
        for (int k = 1; k <= 4; k++) begin
            check("t3_order", m_data, k);
            step(0, 0, 1);
        end
        check("t3_empty", m_valid, 0);
        step(0, 0, 0, 0, 1);
        check("t3_clr_overflow", overflow, 0);
        check("t3_clr_drop_cnt", drop_cnt, 0);

        // Full FIFO, completion coincides with a pop
        for (int k = 1; k <= 4; k++) send_range(W'(k), 31, 0, 0, 0);
        send_range(W'(5), 31, 1, 0, 0);
        send_range(W'(5), 0, 0, 0, 1);
        check("t4_overflow", overflow, 0);
        check("t4_fill", fill, 4);
        check("t4_head", m_data, 2);
        step(0, 0, 0, 1);
        check("t4_flush_fill", fill, 0);

        // rst mid-word
        rnd = W'($urandom);
        send_range(rnd, 31, 15, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        send_range(32'hDEADBEEF, 31, 0, 0, 0);
        check("t5_rst_data", m_data, 32'hDEADBEEF);
        check("t5_rst_fill", fill, 1);
        step(0, 0, 1);

        // flush mid-word, drop count preserved
        for (int k = 0; k < 5; k++) send_range(W'($urandom), 31, 0, 0, 0);
        step(0, 0, 0, 1);
        rnd = W'($urandom);
        send_range(rnd, 31, 15, 0, 0);
        step(1, 1, 0, 1);
        send_range(32'hDEADBEEF, 31, 0, 0, 0);
        check("t5_flush_data", m_data, 32'hDEADBEEF);
        check("t5_flush_fill", fill, 1);
        check("t5_flush_drop_cnt", drop_cnt, 1);
        step(0, 0, 1, 0, 1);

        // Repetition count / all-ones word
        step(0, 0, 1, 0, 0, 1);
`ifdef LFSR_PACK_HEALTH_EN
        send_range(32'hFFFFFFFF, 31, 1, 0, 1);
        check("t6_alarm_pre", alarm, 0);
        send_range(32'hFFFFFFFF, 0, 0, 0, 1);
        check("t6_alarm", alarm, 1);
        check("t6_no_push", m_valid, 0);
        step(0, 0, 1, 0, 1);
        send_range(32'hAAAA5555, 31, 0, 0, 1);
        check("t6_alarm_clr", alarm, 0);
        check("t6_valid", m_valid, 1);
        check("t6_data", m_data, 32'hAAAA5555);
`else
        send_range(32'hFFFFFFFF, 31, 0, 0, 1);
        check("t6_valid", m_valid, 1);
        check("t6_data", m_data, 32'hFFFFFFFF);
`endif
        step(0, 0, 1);

        // Randomized traffic
        pct = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) pct = (c / 500 % 3 == 0) ? 0 : ((c / 500 % 3 == 1) ? 30 : 90);
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 100) < pct,
                 ($urandom % 300) == 0, ($urandom % 250) == 0, ($urandom % 1500) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
